s_mem_checker: RTL and testbench
================================

// Module: s_mem_checker
// PURPOSE
// - Read-side companion to the S-array initialiser. Scans the 256-entry S memory through its read port and reports pass/fail.
// - IDENTITY mode checks s[i]==i, which is the post-init state.
// - PERMUTATION mode checks that every byte value occurs exactly once, which is the post-KSA invariant.
// - Sits beside init/ksa on the S-memory mux. Driven by the top-level controller with the same en/rdy handshake.
// PARAMETERS
// - DEPTH   256  number of S entries scanned (addresses 0..DEPTH-1)
// - ADDR_W  8    address width, equal to $clog2(DEPTH)
// - DATA_W  8    S entry width
// - RD_LAT  1    memory read latency in cycles (1 = registered M10K address; 2 = registered address + q)
// PORTS
// - clk        in   1        system clock (CLOCK_50 at top level)
// - rst        in   1        asynchronous, active-high reset
// - en         in   1        start request; accepted only on a cycle where rdy==1
// - rdy        out  1        idle and able to accept en
// - mode       in   1        0=IDENTITY, 1=PERMUTATION; sampled on the accepting edge
// - addr       out  ADDR_W   S-memory read address
// - rddata     in   DATA_W   S-memory read data, valid RD_LAT cycles after addr
// - pass       out  1        last scan found no error
// - fail       out  1        last scan found at least one error
// - fail_addr  out  ADDR_W   address of the first error in the last scan
// - fail_data  out  DATA_W   rddata observed at fail_addr
// - err_count  out  ADDR_W+1 number of erroneous entries, range 0..DEPTH
// BEHAVIOUR
// - Reset values (asynchronous; takes effect immediately, including mid-scan):
//   - state=IDLE, rdy=1, addr=0
//   - pass=0, fail=0, fail_addr=0, fail_data=0, err_count=0
//   - valid pipe cleared, seen bitmap cleared
// - Handshake:
//   - en&&rdy at edge E0 accepts a run: rdy<=0, mode latched, pass/fail/err_count/fail_* cleared, bitmap cleared.
//   - en while rdy==0 is ignored. en held high across a run starts exactly one new run when rdy returns.
// - FSM states:
//   - IDLE  : rdy=1. en -> ISSUE.
//   - ISSUE : addr steps 0..DEPTH-1, one per cycle. addr==0 is driven in the cycle after E0. After DEPTH-1 -> DRAIN.
//   - DRAIN : waits RD_LAT cycles for the last data -> FINISH.
//   - FINISH: one cycle; pass<=(err_count==0), fail<=~pass, rdy<=1 -> IDLE.
//   - rdy rises exactly DEPTH+RD_LAT+1 edges after E0 (258 with defaults).
// - Data alignment:
//   - An RD_LAT-deep shift register carries {valid, addr}.
//   - rddata is compared in the cycle its tagged address exits the pipe. No bubbles.
// - IDENTITY compare: error iff rddata != tag_addr. This is an 8-bit equality with no truncation.
// - PERMUTATION compare: error iff seen[rddata]==1; then seen[rddata]<=1 unconditionally.
//   - The first occurrence is always legal; only the second and later occurrences are errors.
// - Error recording:
//   - err_count increments per error and saturates at DEPTH (it cannot exceed DEPTH by construction).
//   - fail_addr and fail_data capture only the first error of the run.
//   - The scan always completes; there is no early abort.
// - addr holds DEPTH-1 through DRAIN/FINISH and returns to 0 in IDLE.
// - pass/fail are stable from FINISH until the next accepted en or reset. They are never both 1.
// - The block never writes memory. The top-level mux grants it the read port while rdy==0.
// STRUCTURE
// - Package arc4_pkg holds:
//   - S_DEPTH=256, S_ADDR_W=8, S_DATA_W=8
//   - typedef enum logic [1:0] {CHK_IDLE, CHK_ISSUE, CHK_DRAIN, CHK_FINISH} chk_state_t
//   - typedef enum logic {CHK_IDENTITY, CHK_PERMUTATION} chk_mode_t
// - Sub-module perm_bitmap (DEPTH-bit seen vector):
//   - single-cycle clear, test-and-set port, combinational hit output
// - The FSM, tag pipe and error recording are coded inline.
// TESTING
// - Bench: behavioural S memory with selectable RD_LAT (1 and 2); all cases run at both latencies.
// - 1. Memory s[i]=i, mode=0, pulse en -> rdy low for 258 cycles (RD_LAT=1), pass=1, fail=0, err_count=0.
// - 2. s[i]=i except s[0x37]=0x00, mode=0 -> fail=1, fail_addr=0x37, fail_data=0x00, err_count=1.
// - 3. s[i]=255-i: mode=1 -> pass=1, err_count=0; rerun with mode=0 -> fail, fail_addr=0x00, fail_data=0xFF, err_count=256.
// - 4. Permutation with s[10]=s[20]=0x05 (value 0x0E absent), mode=1 -> fail_addr=20, fail_data=0x05, err_count=1.
// - 5. Assert rst 100 cycles into a scan -> all outputs at reset values in the same cycle; next en gives a clean 258-cycle run.
// - 6. Hold en high during a run plus extra pulses while busy -> exactly one run per rdy window; addr sequence 0..255 unbroken.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared constants and types for the ARC4 S-memory blocks.
// The checker's state and mode encodings live here.
package arc4_pkg;

  localparam int S_DEPTH  = 256;
  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_ISSUE,
    CHK_DRAIN,
    CHK_FINISH
  } chk_state_t;

  typedef enum logic {
    CHK_IDENTITY,
    CHK_PERMUTATION
  } chk_mode_t;

  // One slot of the read-latency pipe: marks which address the returning data belongs to.
  typedef struct packed {
    logic                valid;
    logic [S_ADDR_W-1:0] addr;
  } chk_tag_t;

endpackage

// File: rtl/s_mem_checker_if.sv
// Controller/S-memory side of the checker: en/rdy handshake, read port and scan results.
// master = controller plus memory, slave = checker.
interface s_mem_checker_if;
  import arc4_pkg::*;

  logic                en;
  logic                rdy;
  logic                mode;
  logic [S_ADDR_W-1:0] addr;
  logic [S_DATA_W-1:0] rddata;
  logic                pass;
  logic                fail;
  logic [S_ADDR_W-1:0] fail_addr;
  logic [S_DATA_W-1:0] fail_data;
  logic [S_ADDR_W:0]   err_count;

  modport master (
    output en, mode, rddata,
    input  rdy, addr, pass, fail, fail_addr, fail_data, err_count
  );

  modport slave (
    input  en, mode, rddata,
    output rdy, addr, pass, fail, fail_addr, fail_data, err_count
  );

endinterface

// File: rtl/perm_bitmap.sv
// Seen-value vector for the permutation check: one-cycle clear and a test-and-set port
// whose hit output reflects the bit before this cycle's set.
module perm_bitmap #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             tas_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             hit_o
);

  logic [DEPTH-1:0] seen_q;

  assign hit_o = seen_q[idx_i];

  // NOTE: this vector gets an async reset so a scan aborted by rst leaves no stale
  // marks behind; a RAM-style store without reset would need an explicit clear pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= '0;
    end else if (clr_i) begin
      seen_q <= '0;
    end else if (tas_i) begin
      seen_q[idx_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/s_mem_checker.sv
// Scans the S memory through its read port and reports pass/fail for either the
// identity (s[i]==i) or permutation (each value exactly once) invariant.
module s_mem_checker
  import arc4_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  s_mem_checker_if.slave bus
);

  localparam int                  DC_W       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [S_ADDR_W-1:0] LAST_ADDR  = S_ADDR_W'(S_DEPTH - 1);
  localparam logic [S_ADDR_W:0]   ERR_MAX    = (S_ADDR_W + 1)'(S_DEPTH);
  localparam logic [DC_W-1:0]     DRAIN_LAST = DC_W'(RD_LAT - 1);

  chk_state_t          state_q, state_d;
  chk_mode_t           mode_q, mode_d;
  logic                rdy_q, rdy_d;
  logic [S_ADDR_W-1:0] addr_q, addr_d;
  logic [DC_W-1:0]     drain_q, drain_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic [S_ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [S_DATA_W-1:0] fail_data_q, fail_data_d;
  logic [S_ADDR_W:0]   err_count_q, err_count_d;
  chk_tag_t            pipe_q [RD_LAT];

  chk_tag_t tag;
  logic     accept;
  logic     hit;
  logic     is_err;

  assign tag    = pipe_q[RD_LAT-1];
  assign accept = (state_q == CHK_IDLE) && bus.en;
  assign is_err = tag.valid && ((mode_q == CHK_IDENTITY) ? (bus.rddata != tag.addr) : hit);

  perm_bitmap #(
    .DEPTH (S_DEPTH),
    .IDX_W (S_DATA_W)
  ) u_bitmap (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .tas_i (tag.valid && (mode_q == CHK_PERMUTATION)),
    .idx_i (bus.rddata),
    .hit_o (hit)
  );

  // Tags the address issued this cycle so it lines up with rddata RD_LAT cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: (state_q == CHK_ISSUE), addr: addr_q};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    rdy_d       = rdy_q;
    addr_d      = addr_q;
    drain_d     = drain_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    err_count_d = err_count_q;

    if (is_err) begin
      if (err_count_q == '0) begin
        fail_addr_d = tag.addr;
        fail_data_d = bus.rddata;
      end
      if (err_count_q != ERR_MAX) err_count_d = err_count_q + (S_ADDR_W + 1)'(1);
    end

    unique case (state_q)
      CHK_IDLE: begin
        addr_d = '0;
        if (accept) begin
          state_d     = CHK_ISSUE;
          rdy_d       = 1'b0;
          mode_d      = chk_mode_t'(bus.mode);
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          err_count_d = '0;
        end
      end
      CHK_ISSUE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = CHK_DRAIN;
          drain_d = '0;
        end else begin
          addr_d = addr_q + S_ADDR_W'(1);
        end
      end
      CHK_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = CHK_FINISH;
        else                       drain_d = drain_q + DC_W'(1);
      end
      CHK_FINISH: begin
        pass_d  = (err_count_q == '0);
        fail_d  = (err_count_q != '0);
        rdy_d   = 1'b1;
        addr_d  = '0;
        state_d = CHK_IDLE;
      end
      default: state_d = CHK_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CHK_IDLE;
      mode_q      <= CHK_IDENTITY;
      rdy_q       <= 1'b1;
      addr_q      <= '0;
      drain_q     <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rdy_q       <= rdy_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.addr      = addr_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_data = fail_data_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_s_mem_checker.sv
// Scoreboard bench for s_mem_checker: two DUTs (RD_LAT 1 and 2) scan one shared
// behavioural S memory; per-lane monitors compare each finished scan to a queued model result.
module tb_s_mem_checker;
  import arc4_pkg::*;

  typedef struct {
    bit pass;
    bit fail;
    int errs;
    int faddr;
    int fdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_r [2];
  logic       mode_r;
  logic [7:0] mem [256];

  logic       rdy_w   [2];
  logic [7:0] addr_w  [2];
  logic       pass_w  [2];
  logic       fail_w  [2];
  logic [7:0] faddr_w [2];
  logic [7:0] fdata_w [2];
  logic [8:0] errc_w  [2];

  exp_t exp_q [2][$];
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int lane, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s lane%0d (RD_LAT=%0d): got 0x%0h, expected 0x%0h", name, lane,
               lane + 1, act, exp);
    end
  endtask

  // Reference: identity wants s[i]==i; permutation flags every repeat of an already-seen value.
  function automatic exp_t model(input bit m);
    exp_t e = '{0, 0, 0, 0, 0};
    int   cnt [256];
    for (int i = 0; i < 256; i++) begin
      bit bad;
      bad = m ? (cnt[mem[i]] > 0) : (int'(mem[i]) != i);
      cnt[mem[i]]++;
      if (bad) begin
        if (e.errs == 0) begin
          e.faddr = i;
          e.fdata = mem[i];
        end
        e.errs++;
      end
    end
    e.pass = (e.errs == 0);
    e.fail = !e.pass;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g + 1;
    s_mem_checker_if bus ();
    logic [7:0] q1, q2;

    s_mem_checker #(.RD_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    always @(posedge clk) begin
      q1 <= mem[bus.addr];
      q2 <= q1;
    end

    assign bus.en     = en_r[g];
    assign bus.mode   = mode_r;
    assign bus.rddata = (LAT == 1) ? q1 : q2;
    assign rdy_w[g]   = bus.rdy;
    assign addr_w[g]  = bus.addr;
    assign pass_w[g]  = bus.pass;
    assign fail_w[g]  = bus.fail;
    assign faddr_w[g] = bus.fail_addr;
    assign fdata_w[g] = bus.fail_data;
    assign errc_w[g]  = bus.err_count;

    initial begin : mon
      bit   prev_rdy, busy, broken;
      int   cyc, next_a;
      exp_t e;
      prev_rdy = 1'b1;
      busy     = 1'b0;
      broken   = 1'b0;
      cyc      = 0;
      next_a   = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          busy     = 1'b0;
          prev_rdy = 1'b1;
        end else begin
          if (prev_rdy && !bus.rdy) begin
            busy   = 1'b1;
            cyc    = 0;
            next_a = 0;
            broken = 1'b0;
            check("run_expected", g, exp_q[g].size() != 0, 1);
            check("clr_on_accept", g, {bus.pass, bus.fail, bus.err_count}, 0);
          end
          if (!bus.rdy && busy) begin
            cyc++;
            if (int'(bus.addr) == next_a) next_a++;
            else if (int'(bus.addr) != next_a - 1) broken = 1'b1;
          end
          if (!prev_rdy && bus.rdy && busy) begin
            busy = 1'b0;
            if (exp_q[g].size() != 0) begin
              e = exp_q[g].pop_front();
              check("pass", g, bus.pass, e.pass);
              check("fail", g, bus.fail, e.fail);
              check("err_count", g, bus.err_count, e.errs);
              check("fail_addr", g, bus.fail_addr, e.faddr);
              check("fail_data", g, bus.fail_data, e.fdata);
              check("busy_cycles", g, cyc, 256 + LAT + 1);
              check("addr_seq", g, broken ? 0 : next_a, 256);
            end
          end
          prev_rdy = bus.rdy;
        end
      end
    end
  end

  task automatic push_exp(input bit m);
    exp_t e;
    e = model(m);
    exp_q[0].push_back(e);
    exp_q[1].push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(rdy_w[0] && rdy_w[1]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 0, n < budget, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_en();
    en_r[0] = 1'b1;
    en_r[1] = 1'b1;
    @(negedge clk);
    en_r[0] = 1'b0;
    en_r[1] = 1'b0;
  endtask

  // One accepted run; mode flips after acceptance and stray en pulses land mid-scan.
  task automatic do_run(input bit m, input int pulses);
    push_exp(m);
    mode_r = m;
    @(negedge clk);
    pulse_en();
    mode_r = !m;
    repeat (pulses) begin
      repeat ($urandom_range(5, 40)) @(negedge clk);
      pulse_en();
    end
    wait_idle(600);
  endtask

  task automatic hold_lane(input int g);
    int seen = 0;
    int n = 0;
    bit prev = 1'b1;
    en_r[g] = 1'b1;
    while (seen < 2 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (rdy_w[g] && !prev) seen++;
      prev = rdy_w[g];
    end
    en_r[g] = 1'b0;
    check("held_en_timeout", g, n < 2000, 1);
  endtask

  task automatic check_reset_outputs();
    for (int g = 0; g < 2; g++) begin
      check("rst_rdy", g, rdy_w[g], 1);
      check("rst_addr", g, addr_w[g], 0);
      check("rst_pass_fail", g, {pass_w[g], fail_w[g]}, 0);
      check("rst_fail_info", g, {faddr_w[g], fdata_w[g]}, 0);
      check("rst_err_count", g, errc_w[g], 0);
    end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
  endtask

  task automatic fill_shuffle();
    logic [7:0] t;
    int         j;
    fill_identity();
    for (int i = 255; i > 0; i--) begin
      j      = $urandom_range(0, i);
      t      = mem[i];
      mem[i] = mem[j];
      mem[j] = t;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    en_r[0] = 1'b0;
    en_r[1] = 1'b0;
    mode_r  = 1'b0;
    fill_identity();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Identity memory passes; a single corrupted entry is located.
    do_run(1'b0, 0);
    mem[8'h37] = 8'h00;
    do_run(1'b0, 2);

    // Reversed memory is a valid permutation but fails identity everywhere.
    for (int i = 0; i < 256; i++) mem[i] = 8'(255 - i);
    do_run(1'b1, 0);
    do_run(1'b0, 1);

    // Duplicate 0x05 at 10 and 20, 0x0E missing.
    fill_identity();
    mem[10] = 8'h05;
    mem[20] = 8'h05;
    mem[5]  = 8'h0A;
    mem[14] = 8'h14;
    do_run(1'b1, 1);

    for (int k = 0; k < 5; k++) begin
      fill_shuffle();
      repeat ($urandom_range(0, 3)) mem[$urandom_range(0, 255)] = 8'($urandom);
      do_run(1'($urandom), $urandom_range(0, 3));
    end

    // Reset 100 cycles into a scan, then a clean run.
    fill_shuffle();
    push_exp(1'b1);
    mode_r = 1'b1;
    @(negedge clk);
    pulse_en();
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_run(1'b1, 0);

    // en held across two runs per lane: exactly two scans, no third.
    fill_shuffle();
    mem[$urandom_range(0, 255)] = 8'($urandom);
    push_exp(1'b1);
    push_exp(1'b1);
    mode_r = 1'b1;
    @(negedge clk);
    fork
      hold_lane(0);
      hold_lane(1);
    join
    wait_idle(600);
    repeat (20) @(negedge clk);
    check("queue_drained", 0, exp_q[0].size(), 0);
    check("queue_drained", 1, exp_q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
